// File: rtl/pc_controller_pkg.sv
// Shared encodings for the fetch sequencer: control-flow classes and FSM states.
package pc_controller_pkg;

    localparam int ADDR_W_DEF = 10;

    localparam logic [2:0] TS_SEQ     = 3'd0;
    localparam logic [2:0] TS_BRANCH  = 3'd1;
    localparam logic [2:0] TS_JUMP    = 3'd2;
    localparam logic [2:0] TS_JUMPREG = 3'd3;
    localparam logic [2:0] TS_CALL    = 3'd4;
    localparam logic [2:0] TS_RET     = 3'd5;
    localparam logic [2:0] TS_HALT    = 3'd6;

    typedef enum logic [1:0] {INICIO, EXECUTA, PARADO} estado_t;

endpackage

// File: rtl/pilha_retorno.sv
// Return-address LIFO; the pointer counts occupied entries, so topo reads entry sp-1.
module pilha_retorno #(
    parameter int ADDR_W      = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] dado,
    output logic [ADDR_W-1:0] topo,
    output logic              cheia,
    output logic              vazia
);
    localparam int PW = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [PW:0]       sp;
    logic [PW-1:0]     idx_topo;

    assign idx_topo = sp[PW-1:0] - PW'(1);
    assign topo     = mem[idx_topo];
    assign cheia    = (sp == (PW+1)'(STACK_DEPTH));
    assign vazia    = (sp == '0);

    always_ff @(posedge Clock) begin
        if (!Reset)
            sp <= '0;
        else if (push && !cheia)
            sp <= sp + (PW+1)'(1);
        else if (pop && !vazia)
            sp <= sp - (PW+1)'(1);
    end

    // Storage carries no reset; only the pointer defines validity.
    always_ff @(posedge Clock) begin
        if (Reset && push && !cheia)
            mem[sp[PW-1:0]] <= dado;
    end

endmodule

// File: rtl/pc_controller.sv
// Fetch sequencer: picks the next PC each cycle and drives the PC register load port.
import pc_controller_pkg::*;

module pc_controller #(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PCAtual,
    input  logic [2:0]        TipoSalto,
    input  logic              Condicao,
    input  logic [ADDR_W-1:0] Imediato,
    input  logic [ADDR_W-1:0] RegEndereco,
    input  logic              Stall,
    input  logic              Continuar,
    output logic              PCFunct,
    output logic [ADDR_W-1:0] InstrucaoModificada,
    output logic              Parado,
    output logic              ErroPilha,
    output logic [CNT_W-1:0]  ContInstrucoes
);
    estado_t           estado, estado_prox;
    logic              push, pop, erro_set, cheia, vazia;
    logic [ADDR_W-1:0] topo, pc_inc;

    assign pc_inc = PCAtual + ADDR_W'(1);

    pilha_retorno #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_pilha (
        .Clock (Clock),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .dado  (pc_inc),
        .topo  (topo),
        .cheia (cheia),
        .vazia (vazia)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            estado         <= INICIO;
            Parado         <= 1'b0;
            ErroPilha      <= 1'b0;
            ContInstrucoes <= '0;
        end else begin
            estado <= estado_prox;
            Parado <= (estado_prox == PARADO);
            if (erro_set)
                ErroPilha <= 1'b1;
            if (PCFunct)
                ContInstrucoes <= ContInstrucoes + CNT_W'(1);
        end
    end

    always_comb begin
        estado_prox         = estado;
        PCFunct             = 1'b0;
        InstrucaoModificada = pc_inc;
        push                = 1'b0;
        pop                 = 1'b0;
        erro_set            = 1'b0;
        case (estado)
            INICIO: begin
                InstrucaoModificada = '0;
                estado_prox         = EXECUTA;
            end
            EXECUTA: if (!Stall) begin
                PCFunct = 1'b1;
                case (TipoSalto)
                    TS_BRANCH:  if (Condicao) InstrucaoModificada = Imediato;
                    TS_JUMP:    InstrucaoModificada = Imediato;
                    TS_JUMPREG: InstrucaoModificada = RegEndereco;
                    TS_CALL: begin
                        if (cheia) begin
                            PCFunct     = 1'b0;
                            erro_set    = 1'b1;
                            estado_prox = PARADO;
                        end else begin
                            push                = 1'b1;
                            InstrucaoModificada = Imediato;
                        end
                    end
                    TS_RET: begin
                        if (vazia) begin
                            PCFunct     = 1'b0;
                            erro_set    = 1'b1;
                            estado_prox = PARADO;
                        end else begin
                            pop                 = 1'b1;
                            InstrucaoModificada = topo;
                        end
                    end
                    TS_HALT: begin
                        PCFunct     = 1'b0;
                        estado_prox = PARADO;
                    end
                    default: ;
                endcase
            end
            PARADO: if (Continuar && !Stall && !ErroPilha) begin
                PCFunct     = 1'b1;
                estado_prox = EXECUTA;
            end
            default: estado_prox = INICIO;
        endcase
        // Reset outranks everything: no PC load and no stack traffic.
        if (!Reset) begin
            PCFunct             = 1'b0;
            InstrucaoModificada = '0;
            push                = 1'b0;
            pop                 = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_controller.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_pc_controller;

    logic       Clock = 1'b0;
    logic       Reset, Condicao, Stall, Continuar;
    logic [2:0] TipoSalto;
    logic [9:0] PCAtual, Imediato, RegEndereco;
    logic       PCFunct, Parado, ErroPilha;
    logic [9:0] InstrucaoModificada;
    logic [15:0] ContInstrucoes;

    always #5 Clock = ~Clock;

    pc_controller dut (
        .Clock(Clock), .Reset(Reset), .PCAtual(PCAtual), .TipoSalto(TipoSalto),
        .Condicao(Condicao), .Imediato(Imediato), .RegEndereco(RegEndereco),
        .Stall(Stall), .Continuar(Continuar), .PCFunct(PCFunct),
        .InstrucaoModificada(InstrucaoModificada), .Parado(Parado),
        .ErroPilha(ErroPilha), .ContInstrucoes(ContInstrucoes)
    );

    typedef struct {
        bit rst; logic [2:0] ts; bit cond; logic [9:0] imm, rg, pc; bit stall, cont;
        bit ld; bit cnx; logic [9:0] nx; bit par, err; logic [15:0] cnt;
    } vec_t;

    int checks = 0, failures = 0;

    // Reference model: mode 0=start,1=run,2=halted; stack is a queue.
    int         m_mode, m_cnt;
    bit         m_err, m_par;
    logic [9:0] m_stk[$];
    logic [9:0] m_pc;
    bit         e_ld, e_care, e_push, e_pop, e_seterr;
    logic [9:0] e_nx;
    int         e_mode;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_err = 0; m_par = 0; m_pc = 10'd0;
        m_stk.delete();
    endtask

    task automatic model_eval();
        e_ld = 0; e_push = 0; e_pop = 0; e_seterr = 0; e_mode = m_mode;
        e_nx = PCAtual + 10'd1;
        if (!Reset) begin
            e_nx = 10'd0;
        end else if (m_mode == 0) begin
            e_nx = 10'd0; e_mode = 1;
        end else if (m_mode == 1) begin
            if (!Stall) begin
                if (TipoSalto == 3'd6) e_mode = 2;
                else if (TipoSalto == 3'd4) begin
                    if (m_stk.size() == 4) begin e_seterr = 1; e_mode = 2; end
                    else begin e_push = 1; e_ld = 1; e_nx = Imediato; end
                end else if (TipoSalto == 3'd5) begin
                    if (m_stk.size() == 0) begin e_seterr = 1; e_mode = 2; end
                    else begin e_pop = 1; e_ld = 1; e_nx = m_stk[m_stk.size()-1]; end
                end else begin
                    e_ld = 1;
                    if (TipoSalto == 3'd2 || (TipoSalto == 3'd1 && Condicao)) e_nx = Imediato;
                    if (TipoSalto == 3'd3) e_nx = RegEndereco;
                end
            end
        end else if (Continuar && !Stall && !m_err) begin
            e_ld = 1; e_mode = 1;
        end
        e_care = !Reset || m_mode == 0 || e_ld;
    endtask

    task automatic model_commit();
        if (!Reset) begin
            model_reset();
        end else begin
            if (e_push) m_stk.push_back(PCAtual + 10'd1);
            if (e_pop) void'(m_stk.pop_back());
            if (e_seterr) m_err = 1;
            if (e_ld) begin m_cnt = (m_cnt + 1) % 65536; m_pc = e_nx; end
            m_par = (e_mode == 2);
            m_mode = e_mode;
        end
    endtask

    task automatic step(input vec_t t, input bit tab, input int idx);
        Reset = t.rst; TipoSalto = t.ts; Condicao = t.cond; Imediato = t.imm;
        RegEndereco = t.rg; PCAtual = t.pc; Stall = t.stall; Continuar = t.cont;
        @(negedge Clock);
        model_eval();
        chk($sformatf("m_ld[%0d]", idx), PCFunct, e_ld);
        if (e_care) chk($sformatf("m_nx[%0d]", idx), InstrucaoModificada, e_nx);
        chk($sformatf("m_par[%0d]", idx), Parado, m_par);
        chk($sformatf("m_err[%0d]", idx), ErroPilha, m_err);
        chk($sformatf("m_cnt[%0d]", idx), ContInstrucoes, m_cnt);
        if (tab) begin
            chk($sformatf("t_ld[%0d]", idx), PCFunct, t.ld);
            if (t.cnx) chk($sformatf("t_nx[%0d]", idx), InstrucaoModificada, t.nx);
            chk($sformatf("t_par[%0d]", idx), Parado, t.par);
            chk($sformatf("t_err[%0d]", idx), ErroPilha, t.err);
            chk($sformatf("t_cnt[%0d]", idx), ContInstrucoes, t.cnt);
        end
        @(posedge Clock);
        model_commit();
        #1;
    endtask

    function automatic vec_t v(bit rst, logic [2:0] ts, bit cond, logic [9:0] imm, logic [9:0] pc,
                               bit stall, bit cont, bit ld, bit cnx, logic [9:0] nx,
                               bit par, bit err, logic [15:0] cnt);
        vec_t r;
        r.rst = rst; r.ts = ts; r.cond = cond; r.imm = imm; r.rg = 10'h2AA; r.pc = pc;
        r.stall = stall; r.cont = cont; r.ld = ld; r.cnx = cnx; r.nx = nx;
        r.par = par; r.err = err; r.cnt = cnt;
        return r;
    endfunction

    vec_t vecs[$];

    initial begin
        //                rst ts  c imm     pc      st ct ld cnx nx      par err cnt
        vecs.push_back(v(1, 0, 0, 10'h000, 10'h000, 0, 0, 0, 1, 10'h000, 0, 0, 0));  // INICIO
        vecs.push_back(v(1, 0, 0, 10'h000, 10'h000, 0, 0, 1, 1, 10'h001, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 10'h155, 10'h001, 0, 0, 1, 1, 10'h155, 0, 0, 1));
        vecs.push_back(v(1, 1, 0, 10'h155, 10'h3FF, 0, 0, 1, 1, 10'h000, 0, 0, 2));  // wrap
        vecs.push_back(v(1, 1, 0, 10'h155, 10'h000, 1, 0, 0, 0, 10'h000, 0, 0, 3));  // stall
        vecs.push_back(v(1, 1, 0, 10'h155, 10'h000, 0, 0, 1, 1, 10'h001, 0, 0, 3));
        vecs.push_back(v(1, 4, 0, 10'h100, 10'h010, 0, 0, 1, 1, 10'h100, 0, 0, 4));
        vecs.push_back(v(1, 4, 0, 10'h200, 10'h100, 0, 0, 1, 1, 10'h200, 0, 0, 5));
        vecs.push_back(v(1, 5, 0, 10'h000, 10'h200, 0, 0, 1, 1, 10'h101, 0, 0, 6));
        vecs.push_back(v(1, 5, 0, 10'h000, 10'h101, 0, 0, 1, 1, 10'h011, 0, 0, 7));
        vecs.push_back(v(1, 4, 0, 10'h050, 10'h000, 0, 0, 1, 1, 10'h050, 0, 0, 8));
        vecs.push_back(v(1, 4, 0, 10'h050, 10'h001, 0, 0, 1, 1, 10'h050, 0, 0, 9));
        vecs.push_back(v(1, 4, 0, 10'h050, 10'h002, 0, 0, 1, 1, 10'h050, 0, 0, 10));
        vecs.push_back(v(1, 4, 0, 10'h050, 10'h003, 0, 0, 1, 1, 10'h050, 0, 0, 11));
        vecs.push_back(v(1, 4, 0, 10'h050, 10'h004, 0, 0, 0, 0, 10'h000, 0, 0, 12)); // overflow
        vecs.push_back(v(1, 0, 0, 10'h000, 10'h005, 0, 1, 0, 0, 10'h000, 1, 1, 12));
        vecs.push_back(v(1, 0, 0, 10'h000, 10'h005, 0, 1, 0, 0, 10'h000, 1, 1, 12));
        vecs.push_back(v(0, 0, 0, 10'h000, 10'h005, 0, 0, 0, 1, 10'h000, 1, 1, 12));
        vecs.push_back(v(1, 0, 0, 10'h000, 10'h000, 0, 0, 0, 1, 10'h000, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 10'h000, 10'h000, 0, 0, 1, 1, 10'h001, 0, 0, 0));
        vecs.push_back(v(1, 5, 0, 10'h000, 10'h007, 0, 0, 0, 0, 10'h000, 0, 0, 1));  // underflow
        vecs.push_back(v(1, 0, 0, 10'h000, 10'h007, 0, 1, 0, 0, 10'h000, 1, 1, 1));
        vecs.push_back(v(0, 0, 0, 10'h000, 10'h007, 0, 0, 0, 1, 10'h000, 1, 1, 1));
        vecs.push_back(v(1, 0, 0, 10'h000, 10'h000, 0, 0, 0, 1, 10'h000, 0, 0, 0));
        vecs.push_back(v(1, 6, 0, 10'h000, 10'h020, 0, 0, 0, 0, 10'h000, 0, 0, 0));  // HALT
        vecs.push_back(v(1, 0, 0, 10'h000, 10'h020, 1, 1, 0, 0, 10'h000, 1, 0, 0));
        vecs.push_back(v(1, 0, 0, 10'h000, 10'h020, 0, 1, 1, 1, 10'h021, 1, 0, 0));
        vecs.push_back(v(1, 4, 0, 10'h080, 10'h021, 0, 0, 1, 1, 10'h080, 0, 0, 1));
        vecs.push_back(v(0, 4, 0, 10'h090, 10'h080, 0, 0, 0, 1, 10'h000, 0, 0, 2));  // reset mid-CALL
        vecs.push_back(v(1, 0, 0, 10'h000, 10'h000, 0, 0, 0, 1, 10'h000, 0, 0, 0));
        vecs.push_back(v(1, 5, 0, 10'h000, 10'h000, 0, 0, 0, 0, 10'h000, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 10'h000, 10'h001, 0, 0, 0, 0, 10'h000, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 1, 10'h000, 1, 1, 0));
        vecs.push_back(v(1, 0, 0, 10'h000, 10'h000, 0, 0, 0, 1, 10'h000, 0, 0, 0));

        Reset = 1'b0; TipoSalto = 3'd0; Condicao = 1'b0; Imediato = '0;
        RegEndereco = '0; PCAtual = '0; Stall = 1'b0; Continuar = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        model_reset();

        foreach (vecs[i]) step(vecs[i], 1'b1, i);

        for (int i = 0; i < 3000; i++) begin
            vec_t t;
            t = v(1, 0, 0, 10'h000, m_pc, 0, 0, 0, 0, 10'h000, 0, 0, 0);
            t.rst   = ($urandom_range(99) >= (m_err ? 10 : 1));
            t.ts    = 3'($urandom_range(7));
            t.cond  = 1'($urandom_range(1));
            t.imm   = 10'($urandom);
            t.rg    = 10'($urandom);
            t.stall = ($urandom_range(3) == 0);
            t.cont  = 1'($urandom_range(1));
            step(t, 1'b0, 1000 + i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_controller.md
# pc_controller

Fetch sequencer that drives the program counter's load interface (`PCFunct`, `InstrucaoModificada`). Each cycle it selects the next instruction address from the decoded control-flow class, the ALU condition flag, an immediate and a register operand. It also handles pipeline stall, halt/resume and call/return through a small return-address stack. It sits between the control unit/ALU and the PC register; the PC register's output feeds back as `PCAtual`.

## Interface
- `ADDR_W`, 10: instruction address width.
- `STACK_DEPTH`, 4: return-address stack entries (power of two, ≥2).
- `CNT_W`, 16: retired-instruction counter width.

- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  synchronous, active-low; sampled on rising edge of `Clock`.
- `PCAtual`  in  ADDR_W  current PC value.
- `TipoSalto`  in  3  control-flow class: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JUMPREG, 4 CALL, 5 RET, 6 HALT, 7 reserved (treated as SEQ).
- `Condicao`  in  1  ALU flag; BRANCH taken when 1.
- `Imediato`  in  ADDR_W  absolute target for BRANCH/JUMP/CALL.
- `RegEndereco`  in  ADDR_W  target for JUMPREG.
- `Stall`  in  1  freeze PC this cycle.
- `Continuar`  in  1  resume request while halted.
- `PCFunct`  out  1  PC load enable.
- `InstrucaoModificada`  out  ADDR_W  next PC value.
- `Parado`  out  1  controller halted.
- `ErroPilha`  out  1  sticky stack overflow/underflow flag.
- `ContInstrucoes`  out  CNT_W  count of cycles with `PCFunct`=1.

## Operation
- States: INICIO, EXECUTA, PARADO.
- Reset (`Reset`=0 at edge): state INICIO, stack pointer 0, `ErroPilha`=0, `ContInstrucoes`=0.
- INICIO lasts one cycle: `PCFunct`=0, `InstrucaoModificada`=0. The PC register holds its own reset value of 0. Next state is EXECUTA.
- EXECUTA with `Stall`=1: `PCFunct`=0, no stack or counter change, state held. `InstrucaoModificada` = PC+1 (don't-care).
- EXECUTA with `Stall`=0, `PCFunct`=1 unless noted. Next-PC selection:
  - SEQ/reserved: `PCAtual`+1.
  - BRANCH: `Imediato` if `Condicao` else `PCAtual`+1.
  - JUMP: `Imediato`.
  - JUMPREG: `RegEndereco`.
  - CALL: `Imediato`; push `PCAtual`+1.
  - RET: pop, output the popped value.
  - HALT: `PCFunct`=0; go to PARADO.
- Stack boundaries, in EXECUTA:
  - CALL when full: no push, `PCFunct`=0, set `ErroPilha`, go to PARADO.
  - RET when empty: no pop, `PCFunct`=0, set `ErroPilha`, go to PARADO.
- PARADO: `Parado`=1, `PCFunct`=0, `TipoSalto` ignored.
  - `Continuar`=1 with `Stall`=0 and `ErroPilha`=0: `PCFunct`=1, `InstrucaoModificada`=`PCAtual`+1, go to EXECUTA.
  - With `ErroPilha`=1, only reset exits PARADO.
- Arithmetic: all address adds are modulo 2^ADDR_W (1023+1 → 0 for default width). `ContInstrucoes` wraps at 2^CNT_W.

## Timing
- `PCFunct`, `InstrucaoModificada`: combinational from registered state, stack top and current inputs. The PC loads at the same rising edge, so next-PC latency is zero cycles and PC update takes one edge.
- Stack push/pop, `ErroPilha`, state and counter update on the rising edge of `Clock`.
- `Parado` and `ErroPilha` are registered. `Parado` asserts the cycle after HALT or the error is sampled.
- Priority: `Reset` > `Stall` > `TipoSalto`/`Continuar`.
- `Stall` and `Continuar` together in PARADO: stays halted; `Continuar` must be held until `Stall`=0.
- Reset mid-CALL/RET: the stack operation is discarded; the stack is empty after reset.
- Reset values: `PCFunct`=0, `InstrucaoModificada`=0, `Parado`=0, `ErroPilha`=0, `ContInstrucoes`=0.

## Structure
- Package `pc_controller_pkg`:
  - `TipoSalto` encoding constants.
  - State enum (INICIO/EXECUTA/PARADO).
  - Default `ADDR_W`.
- Sub-module `pilha_retorno`:
  - Parameterized LIFO (ADDR_W × STACK_DEPTH).
  - Inputs: push, pop, push data.
  - Outputs: `topo`, `cheia`, `vazia`.
  - Synchronous active-low reset clears the pointer.
- Top level contains only the FSM, the next-PC mux, the error flag and the counter.

## Test plan
- Reset release: INICIO cycle gives `PCFunct`=0, `InstrucaoModificada`=0. Next cycle with SEQ and `PCAtual`=0 gives `PCFunct`=1, `InstrucaoModificada`=1. `ContInstrucoes` counts 1 after that edge.
- BRANCH with `Imediato`=0x155:
  - `Condicao`=1 → 0x155.
  - `Condicao`=0 with `PCAtual`=0x3FF → 0x000 (wrap).
  - `Stall`=1 → `PCFunct`=0 and counter unchanged.
- Nested CALLs: from `PCAtual`=0x10 to 0x100, then from 0x100 to 0x200. RET → 0x101, RET → 0x011. Fifth CALL after 4 pushes → `ErroPilha`=1, `Parado`=1, `PCFunct`=0.
- RET on empty stack → `ErroPilha`=1. `Continuar`=1 is then ignored. `Reset`=0 for one edge clears the flag and `Parado`, and returns to INICIO.
- HALT at `PCAtual`=0x020 → `Parado`=1 next cycle.
  - `Continuar`=1 with `Stall`=1 → stays halted.
  - `Continuar`=1 with `Stall`=0 → `PCFunct`=1, `InstrucaoModificada`=0x021, back in EXECUTA.
- `Reset`=0 asserted in the same cycle as a CALL → no push. A subsequent RET flags underflow.
